// File: rtl/product_collector_if.sv
// Operand/result bundle for product_collector.
// The master side feeds operand pairs, flush and the frame acknowledge;
// the slave side (the collector) returns ready, Enable, the five products
// and the acknowledged-frame count.
interface product_collector_if #(
    parameter int Bit_width = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [Bit_width-1:0]     in_data;
    logic [Bit_width-1:0]     in_weight;
    logic                     flush;
    logic                     Enable;
    logic [2*Bit_width-1:0]   Mul_result_0;
    logic [2*Bit_width-1:0]   Mul_result_1;
    logic [2*Bit_width-1:0]   Mul_result_2;
    logic [2*Bit_width-1:0]   Mul_result_3;
    logic [2*Bit_width-1:0]   Mul_result_4;
    logic                     out_ack;
    logic [7:0]               frame_count;

    modport master (
        output in_valid, in_data, in_weight, flush, out_ack,
        input  in_ready, Enable, frame_count,
        input  Mul_result_0, Mul_result_1, Mul_result_2, Mul_result_3, Mul_result_4
    );

    modport slave (
        input  in_valid, in_data, in_weight, flush, out_ack,
        output in_ready, Enable, frame_count,
        output Mul_result_0, Mul_result_1, Mul_result_2, Mul_result_3, Mul_result_4
    );
endinterface

// File: rtl/product_collector.sv
// product_collector: gathers five operand-pair products into registered
// slots, then holds them (Enable=1) until the downstream summing stage
// acknowledges the frame.
// Build option: define PRODUCT_COLLECTOR_SIGNED_MUL_EN for two's-complement
// operands; the default build multiplies unsigned operands.
module product_collector #(
    parameter int Bit_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    product_collector_if.slave   bus
);
    localparam int PW = 2 * Bit_width;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t          state_q;
    logic [2:0]      idx_q;
    logic [7:0]      frame_count_q;
    logic [PW-1:0]   slot_q [5];

    logic [PW-1:0]   data_ext;
    logic [PW-1:0]   weight_ext;
    logic [PW-1:0]   product_d;

    // Widen both operands to the product width; the low PW bits of the
    // widened product are exact for both signed and unsigned operands.
    always_comb begin
`ifdef PRODUCT_COLLECTOR_SIGNED_MUL_EN
        data_ext   = {{Bit_width{bus.in_data[Bit_width-1]}}, bus.in_data};
        weight_ext = {{Bit_width{bus.in_weight[Bit_width-1]}}, bus.in_weight};
`else
        data_ext   = {{Bit_width{1'b0}}, bus.in_data};
        weight_ext = {{Bit_width{1'b0}}, bus.in_weight};
`endif
        product_d  = data_ext * weight_ext;
    end

    // Collect/hold state machine with slot registers and frame counter;
    // reset beats everything, flush beats a same-edge transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= COLLECT;
            idx_q         <= 3'd0;
            frame_count_q <= 8'd0;
            for (int i = 0; i < 5; i++) slot_q[i] <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (bus.flush) begin
                        idx_q <= 3'd0;
                        for (int i = 0; i < 5; i++) slot_q[i] <= '0;
                    end else if (bus.in_valid) begin
                        for (int i = 0; i < 5; i++) begin
                            if (idx_q == 3'(i)) slot_q[i] <= product_d;
                        end
                        if (idx_q == 3'd4) begin
                            idx_q   <= 3'd0;
                            state_q <= FULL;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                FULL: begin
                    if (bus.out_ack) begin
                        state_q       <= COLLECT;
                        frame_count_q <= frame_count_q + 8'd1;
                        for (int i = 0; i < 5; i++) slot_q[i] <= '0;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                    idx_q   <= 3'd0;
                end
            endcase
        end
    end

    assign bus.in_ready     = (state_q == COLLECT);
    assign bus.Enable       = (state_q == FULL);
    assign bus.frame_count  = frame_count_q;
    assign bus.Mul_result_0 = slot_q[0];
    assign bus.Mul_result_1 = slot_q[1];
    assign bus.Mul_result_2 = slot_q[2];
    assign bus.Mul_result_3 = slot_q[3];
    assign bus.Mul_result_4 = slot_q[4];
endmodule

// File: tb/tb_product_collector.sv
// Directed self-checking bench for product_collector (Bit_width = 8).
// Expected products that depend on PRODUCT_COLLECTOR_SIGNED_MUL_EN are
// selected with the same macro so either build can be checked.
module tb_product_collector;
    localparam int W  = 8;
    localparam int PW = 2 * W;

    typedef logic [4:0][PW-1:0] res_t;

`ifdef PRODUCT_COLLECTOR_SIGNED_MUL_EN
    localparam logic [PW-1:0] P_255_255 = 16'h0001;
    localparam logic [PW-1:0] P_255_127 = 16'hFF81;
`else
    localparam logic [PW-1:0] P_255_255 = 16'd65025;
    localparam logic [PW-1:0] P_255_127 = 16'h7E81;
`endif

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    product_collector_if #(.Bit_width(W)) bus ();

    product_collector #(.Bit_width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t readResults();
        return {bus.Mul_result_4, bus.Mul_result_3, bus.Mul_result_2,
                bus.Mul_result_1, bus.Mul_result_0};
    endfunction

    task automatic sendPair(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid  = 1'b1;
        bus.in_data   = a;
        bus.in_weight = b;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic pulseAck();
        bus.out_ack = 1'b1;
        tick();
        bus.out_ack = 1'b0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_weight = '0;
        bus.flush     = 1'b0;
        bus.out_ack   = 1'b0;
        applyReset();
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        checks++;
        if (bus.Enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_enable got=%b exp=0", bus.Enable);
        end
        checks++;
        if (readResults() !== res_t'(0)) begin
            failures++;
            $display("[TB] FAIL reset_results got=%h exp=0", readResults());
        end
        checks++;
        if (bus.frame_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_frame_count got=%0d exp=0", bus.frame_count);
        end
    endtask

    task automatic test_basic_frame();
        res_t exp;
        exp = {P_255_255, 16'd56, 16'd30, 16'd12, 16'd2};
        sendPair(8'd1, 8'd2);
        sendPair(8'd3, 8'd4);
        sendPair(8'd5, 8'd6);
        sendPair(8'd7, 8'd8);
        checks++;
        if (bus.Enable !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_before_fifth got enable=%b ready=%b exp enable=0 ready=1",
                     bus.Enable, bus.in_ready);
        end
        sendPair(8'd255, 8'd255);
        checks++;
        if (bus.Enable !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_full got enable=%b ready=%b exp enable=1 ready=0",
                     bus.Enable, bus.in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (readResults()[i] !== exp[i]) begin
                failures++;
                $display("[TB] FAIL basic_result_%0d got=%0d exp=%0d", i, readResults()[i], exp[i]);
            end
        end
    endtask

    task automatic test_hold_release();
        res_t exp;
        exp = {P_255_255, 16'd56, 16'd30, 16'd12, 16'd2};
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'd9;
        bus.in_weight = 8'd9;
        bus.flush     = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus.Enable !== 1'b1 || bus.in_ready !== 1'b0 || readResults() !== exp) begin
                failures++;
                $display("[TB] FAIL hold_cycle_%0d got enable=%b results=%h exp enable=1 results=%h",
                         c, bus.Enable, readResults(), exp);
            end
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        pulseAck();
        checks++;
        if (bus.Enable !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_state got enable=%b ready=%b exp enable=0 ready=1",
                     bus.Enable, bus.in_ready);
        end
        checks++;
        if (readResults() !== res_t'(0)) begin
            failures++;
            $display("[TB] FAIL release_results got=%h exp=0", readResults());
        end
        checks++;
        if (bus.frame_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL release_frame_count got=%0d exp=1", bus.frame_count);
        end
    endtask

    task automatic test_ack_ignored_in_collect();
        bus.out_ack = 1'b1;
        tick();
        tick();
        bus.out_ack = 1'b0;
        checks++;
        if (bus.frame_count !== 8'd1 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ack_in_collect got count=%0d ready=%b exp count=1 ready=1",
                     bus.frame_count, bus.in_ready);
        end
    endtask

    task automatic test_flush_collision();
        res_t exp;
        sendPair(8'd2, 8'd3);
        sendPair(8'd4, 8'd5);
        exp = {16'd0, 16'd0, 16'd0, 16'd20, 16'd6};
        checks++;
        if (readResults() !== exp) begin
            failures++;
            $display("[TB] FAIL partial_slots got=%h exp=%h", readResults(), exp);
        end
        bus.flush = 1'b1;
        sendPair(8'd10, 8'd10);
        bus.flush = 1'b0;
        checks++;
        if (readResults() !== res_t'(0) || bus.Enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_collision got results=%h enable=%b exp results=0 enable=0",
                     readResults(), bus.Enable);
        end
        sendPair(8'd10, 8'd1);
        sendPair(8'd20, 8'd1);
        sendPair(8'd30, 8'd1);
        sendPair(8'd40, 8'd1);
        checks++;
        if (bus.Enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fresh_frame_early_enable got=%b exp=0", bus.Enable);
        end
        sendPair(8'd50, 8'd1);
        exp = {16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
        checks++;
        if (bus.Enable !== 1'b1 || readResults() !== exp) begin
            failures++;
            $display("[TB] FAIL fresh_frame got enable=%b results=%h exp enable=1 results=%h",
                     bus.Enable, readResults(), exp);
        end
        pulseAck();
        checks++;
        if (bus.frame_count !== 8'd2) begin
            failures++;
            $display("[TB] FAIL fresh_frame_count got=%0d exp=2", bus.frame_count);
        end
    endtask

    task automatic test_signed_mode();
        sendPair(8'hFF, 8'd127);
        checks++;
        if (bus.Mul_result_0 !== P_255_127) begin
            failures++;
            $display("[TB] FAIL mul_mode_slot0 got=%h exp=%h", bus.Mul_result_0, P_255_127);
        end
        checks++;
        if (bus.Mul_result_1 !== 16'd0) begin
            failures++;
            $display("[TB] FAIL unused_slot1 got=%h exp=0", bus.Mul_result_1);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.Mul_result_0 !== 16'd0) begin
            failures++;
            $display("[TB] FAIL flush_clears got=%h exp=0", bus.Mul_result_0);
        end
    endtask

    task automatic test_reset_mid_frame();
        res_t exp;
        sendPair(8'd9, 8'd9);
        sendPair(8'd8, 8'd8);
        sendPair(8'd7, 8'd7);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'd6;
        bus.in_weight = 8'd6;
        applyReset();
        bus.in_valid  = 1'b0;
        tick();
        checks++;
        if (readResults() !== res_t'(0) || bus.in_ready !== 1'b1 || bus.Enable !== 1'b0
            || bus.frame_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_frame got results=%h ready=%b enable=%b count=%0d exp 0/1/0/0",
                     readResults(), bus.in_ready, bus.Enable, bus.frame_count);
        end
        sendPair(8'd3, 8'd7);
        sendPair(8'd11, 8'd13);
        sendPair(8'd100, 8'd50);
        sendPair(8'd17, 8'd19);
        sendPair(8'd127, 8'd2);
        exp = {16'd254, 16'd323, 16'd5000, 16'd143, 16'd21};
        checks++;
        if (bus.Enable !== 1'b1 || readResults() !== exp) begin
            failures++;
            $display("[TB] FAIL post_reset_frame got enable=%b results=%h exp enable=1 results=%h",
                     bus.Enable, readResults(), exp);
        end
        bus.out_ack = 1'b1;
        applyReset();
        bus.out_ack = 1'b0;
        tick();
        checks++;
        if (bus.Enable !== 1'b0 || bus.frame_count !== 8'd0 || readResults() !== res_t'(0)) begin
            failures++;
            $display("[TB] FAIL reset_in_full got enable=%b count=%0d results=%h exp 0/0/0",
                     bus.Enable, bus.frame_count, readResults());
        end
    endtask

    task automatic test_wrap();
        for (int f = 1; f <= 257; f++) begin
            for (int p = 0; p < 5; p++) sendPair(8'd1, 8'd1);
            pulseAck();
            if (f == 255) begin
                checks++;
                if (bus.frame_count !== 8'd255) begin
                    failures++;
                    $display("[TB] FAIL count_255 got=%0d exp=255", bus.frame_count);
                end
            end
            if (f == 256) begin
                checks++;
                if (bus.frame_count !== 8'd0) begin
                    failures++;
                    $display("[TB] FAIL count_wrap got=%0d exp=0", bus.frame_count);
                end
            end
        end
        checks++;
        if (bus.frame_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL count_257 got=%0d exp=1", bus.frame_count);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        test_reset();
        test_basic_frame();
        test_hold_release();
        test_ack_ignored_in_collect();
        test_flush_collision();
        test_signed_mode();
        test_reset_mid_frame();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/product_collector.md
PRODUCT_COLLECTOR -- requirements
Module: product_collector

Interface
REQ-001 SHALL have parameter Bit_width, default 8, giving the operand width in bits; products are 2*Bit_width bits.
REQ-002 SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  operand pair present on in_data/in_weight.
REQ-006 in_ready  output  1  block can accept a pair this cycle.
REQ-007 in_data  input  Bit_width  activation operand.
REQ-008 in_weight  input  Bit_width  weight operand.
REQ-009 flush  input  1  discard the partially collected frame.
REQ-010 Enable  output  1  all five products valid; drives the downstream summing stage.
REQ-011 Mul_result_0 .. Mul_result_4  output  2*Bit_width each  registered products, slot 0 to slot 4.
REQ-012 out_ack  input  1  downstream has consumed the current frame.
REQ-013 frame_count  output  8  number of frames acknowledged, modulo 256.

Function
REQ-014 SHALL implement two states: COLLECT and FULL.
REQ-015 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 in COLLECT and 0 in FULL.
REQ-017 Each transfer SHALL register in_data*in_weight, at full 2*Bit_width width with no truncation, into slot idx.
REQ-018 Each transfer SHALL then increment idx, a 3-bit counter with range 0..4.
REQ-019 The transfer with idx=4 SHALL move the block to FULL and reset idx to 0.
REQ-020 Enable SHALL be 1 exactly when the block is in FULL, so Enable rises one cycle after the fifth transfer.
REQ-021 Mul_result_0..4 SHALL stay stable for the whole time Enable=1.
REQ-022 In FULL, out_ack=1 SHALL return the block to COLLECT on the next edge and increment frame_count.
REQ-023 frame_count SHALL wrap from 255 to 0.
REQ-024 On that same out_ack edge, all Mul_result outputs SHALL clear to 0.
REQ-025 out_ack SHALL be ignored in COLLECT.
REQ-026 In COLLECT, flush=1 SHALL reset idx to 0 and clear all slots to 0.
REQ-027 If flush and a transfer occur on the same edge, flush SHALL win and the pair SHALL be discarded.
REQ-028 flush SHALL be ignored in FULL, so a complete frame is never dropped.
REQ-029 in_valid with in_ready=0 SHALL have no effect.
REQ-030 Unused Mul_result slots SHALL read 0 until they are written in the current frame.

Reset
REQ-031 When rst_n=0 at a rising edge, the block SHALL enter COLLECT.
REQ-032 Reset SHALL set idx=0, Enable=0, Mul_result_0..4=0 and frame_count=0.
REQ-033 in_ready SHALL read 1 on the first cycle after reset is released.
REQ-034 Reset SHALL take priority over flush, out_ack and any transfer.
REQ-035 Reset asserted mid-frame or in FULL SHALL discard the frame without incrementing frame_count.

Configuration
REQ-036 Macro PRODUCT_COLLECTOR_SIGNED_MUL_EN SHALL select the multiply mode.
REQ-037 With PRODUCT_COLLECTOR_SIGNED_MUL_EN defined, operands SHALL be treated as two's-complement and products sign-extended to 2*Bit_width.
REQ-038 Without PRODUCT_COLLECTOR_SIGNED_MUL_EN, operands and products SHALL be unsigned.

Verification
REQ-039 Basic frame: five back-to-back pairs (1,2),(3,4),(5,6),(7,8),(255,255), Bit_width=8, unsigned -> Enable=1 one cycle after the fifth transfer, outputs 2,12,30,56,65025, in_ready=0.
REQ-040 Hold and release: after REQ-039, hold out_ack=0 for 10 cycles and keep in_valid=1 -> no transfer, outputs stable; then pulse out_ack -> COLLECT, outputs 0, frame_count=1.
REQ-041 Flush collision: two transfers, then in_valid=1 together with flush=1 -> idx=0, all slots 0; the next five pairs form a fresh frame.
REQ-042 Wrap-around: complete and acknowledge 257 frames -> frame_count=1.
REQ-043 Reset mid-frame: rst_n=0 after three transfers -> all outputs 0 and in_ready=1 after release; a subsequent full frame yields correct products.
REQ-044 Signed mode, with the macro defined: pair (-1,127) in slot 0 -> Mul_result_0=16'hFF81; without the macro the same bits (255,127) -> 16'h7E81.
